dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
Two-port arbiter and access sequencer in front of the byte-addressed, big-endian data memory. Port 0 is the pipeline MEM stage; port 1 is the loader/DMA port. The block picks one requester, checks alignment, range and control code, and drives the memory for exactly one cycle. It then returns registered read data or an error, while the pipeline stalls on the busy output.

Parameters:
DEPTH, 2048, number of addressable bytes; a legal access must satisfy addr + size - 1 <= DEPTH - 1.
STARVE_LIMIT, 4, number of consecutive port-0 grants while port 1 is waiting; after this many, port 1 is forced to win the next arbitration.

Ports:
clk  in  1  rising-edge clock.
rst_n  in  1  asynchronous, active-low reset.
p0_req / p1_req  in  1  request; held with its fields stable until the matching gnt.
p0_we / p1_we  in  1  1 = store, 0 = load.
p0_ctrl / p1_ctrl  in  3  access code: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu.
p0_addr / p1_addr  in  32  byte address.
p0_wdata / p1_wdata  in  32  store data, right-justified.
p0_gnt / p1_gnt  out  1  combinational accept, asserted in IDLE for the winner only.
p0_done / p1_done  out  1  one-cycle completion pulse for the owning port.
rsp_rdata  out  32  registered load result; 0 for stores and for errors.
rsp_err  out  1  valid together with done; 1 = access rejected.
busy  out  1  high whenever state != IDLE.
mem_addr  out  32  memory address.
mem_wdata  out  32  memory write data.
mem_wr  out  1  memory write enable.
mem_ctrl  out  3  memory access code.
mem_rdata  in  32  memory read data (combinational).

Behaviour:
- Clock and reset: single clock clk; rst_n is asynchronous and active-low.
- Reset values: state IDLE, streak counter 0, all registered outputs 0.
- While in reset, mem_wr is 0, gnt is 0 and done is 0.
- A reset asserted during ACCESS drops mem_wr immediately; the memory contents after that are unspecified.
- FSM states: IDLE -> ACCESS -> RESP -> IDLE, or IDLE -> RESP directly on error.
- IDLE, winner selection:
  - Only p0_req high: port 0 wins.
  - Only p1_req high: port 1 wins.
  - Both high: port 0 wins, unless streak == STARVE_LIMIT, in which case port 1 wins.
- IDLE, on a grant:
  - Assert the winner's gnt in that same cycle.
  - Latch owner, we, ctrl, addr and wdata into internal registers.
  - Compute err into a register.
- Error conditions (any one sets err):
  - ctrl is 011, 110 or 111.
  - Halfword access with addr[0] = 1.
  - Word access with addr[1:0] != 0.
  - Out-of-range address, using size 1, 2 or 4 bytes.
- Next state from IDLE: err -> RESP; otherwise -> ACCESS.
- Streak counter, updated on each grant:
  - Port-0 grant while p1_req = 1: streak increments, saturating at STARVE_LIMIT.
  - Port-0 grant while p1_req = 0: streak clears.
  - Any port-1 grant: streak clears.
- ACCESS, exactly one cycle:
  - mem_addr and mem_wdata come from the latched values.
  - mem_wr equals the latched we.
  - mem_ctrl equals the latched ctrl; for stores, bit 2 is forced to 0 (100 -> 000, 101 -> 001).
  - At the closing edge, rsp_rdata captures mem_rdata for loads, or 0 for stores.
- Outside ACCESS, mem_wr = 0 and mem_addr, mem_wdata and mem_ctrl hold their last values.
- RESP, one cycle:
  - The owner's done = 1 and rsp_err = err.
  - rsp_rdata is valid, and forced to 0 when err = 1.
  - Next state is IDLE.
- Latency: grant at cycle N, ACCESS at N+1, done at N+2 (error case: done at N+1).
- Back-to-back: a new grant is possible in the cycle after RESP, so the peak rate is one access per 3 cycles.
- Request rules:
  - A request arriving while busy waits; it is not dropped.
  - A requester deasserting req before gnt is legal and causes no access.
- Sign and zero extension are performed by the memory as selected by ctrl; this block does not modify the data.

Test Plan:
- Reset then idle -> all outputs 0, busy 0, mem_wr never 1.
- Port 0 store sw (ctrl 010) to addr 0x10, data 0xDEADBEEF; then lw from 0x10 -> gnt at N, mem_wr = 1 only at N+1, done at N+2, rsp_rdata = 0xDEADBEEF, err 0.
- Port 1 sb with ctrl 100 to 0x21, data 0x80; then lb and lbu from 0x21 -> mem_ctrl = 000 on the store; lb returns 0xFFFFFF80; lbu returns 0x00000080.
- Errors, each -> done one cycle after gnt, err 1, rdata 0, no mem_wr pulse:
  - lh at 0x3.
  - lw at 0x6.
  - ctrl 111.
  - lw at 0x7FE with DEPTH = 2048 (exceeds the range).
- Both ports requesting continuously with STARVE_LIMIT = 4 -> grant order 0,0,0,0,1,0,0,0,0,1.
- rst_n pulsed low mid-ACCESS -> mem_wr and done drop asynchronously; FSM returns to IDLE; the next request completes normally.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Two-port arbiter and access sequencer in front of the byte-addressed,
// big-endian data memory. Port 0 is the pipeline MEM stage, port 1 the
// loader/DMA port. One requester is accepted in IDLE. Its alignment, range
// and access code are checked, and the memory is driven for exactly one
// ACCESS cycle. The registered result, or an error, is returned in RESP.
//
// State table:
//   IDLE   | no access in flight; winner of arbitration gets gnt
//   ACCESS | memory driven for one cycle from the latched request
//   RESP   | owner's done pulses with rsp_err / rsp_rdata valid
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   p0_*/p1_* req/we/ctrl/addr/wdata   request fields (held until gnt)
//   p0_gnt/p1_gnt           combinational accept (IDLE, winner only)
//   p0_done/p1_done         one-cycle completion pulse for the owner
//   rsp_rdata, rsp_err      response data / reject flag, valid with done
//   busy                    high whenever the sequencer is not idle
//   mem_addr/mem_wdata/mem_wr/mem_ctrl/mem_rdata   memory interface
module dmem_arbiter #(
    parameter int DEPTH        = 2048,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [2:0]  p0_ctrl,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [2:0]  p1_ctrl,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    output logic        p0_gnt,
    output logic        p1_gnt,
    output logic        p0_done,
    output logic        p1_done,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_wr,
    output logic [2:0]  mem_ctrl,
    input  logic [31:0] mem_rdata
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [SW-1:0]  streak;
    logic           owner;
    logic           we_q;
    logic           err_q;

    logic           grant;
    logic           pick_p1;
    logic           sel_we;
    logic [2:0]     sel_ctrl;
    logic [31:0]    sel_addr;
    logic [31:0]    sel_wdata;
    logic [2:0]     sel_size;
    logic           bad_ctrl;
    logic           misalign;
    logic           out_of_range;
    logic           sel_err;

    // Port 1 only beats a simultaneous port-0 request once port 0 has been
    // granted STARVE_LIMIT times in a row while port 1 was waiting.
    assign pick_p1 = p1_req & (~p0_req | (streak == SW'(STARVE_LIMIT)));
    assign grant   = (state == IDLE) & (p0_req | p1_req);

    assign sel_we    = pick_p1 ? p1_we    : p0_we;
    assign sel_ctrl  = pick_p1 ? p1_ctrl  : p0_ctrl;
    assign sel_addr  = pick_p1 ? p1_addr  : p0_addr;
    assign sel_wdata = pick_p1 ? p1_wdata : p0_wdata;

    always_comb begin
        sel_size = 3'd1;
        bad_ctrl = 1'b0;
        misalign = 1'b0;
        case (sel_ctrl)
            3'b000, 3'b100: sel_size = 3'd1;
            3'b001, 3'b101: begin
                sel_size = 3'd2;
                misalign = sel_addr[0];
            end
            3'b010: begin
                sel_size = 3'd4;
                misalign = |sel_addr[1:0];
            end
            default: bad_ctrl = 1'b1;
        endcase
    end

    // 33-bit sum so an address near 2^32 cannot wrap into range.
    assign out_of_range = ({1'b0, sel_addr} + {30'd0, sel_size}) > 33'(DEPTH);
    assign sel_err      = bad_ctrl | misalign | out_of_range;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant) state_nxt = sel_err ? RESP : ACCESS;
            ACCESS:  state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            streak    <= '0;
            owner     <= 1'b0;
            we_q      <= 1'b0;
            err_q     <= 1'b0;
            rsp_rdata <= 32'd0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            mem_ctrl  <= 3'd0;
        end else begin
            if (grant) begin
                owner <= pick_p1;
                we_q  <= sel_we;
                err_q <= sel_err;
                if (pick_p1 || !p1_req) begin
                    streak <= '0;
                end else if (streak != SW'(STARVE_LIMIT)) begin
                    streak <= streak + 1'b1;
                end
                // The memory-side registers are only loaded for accesses that
                // will actually reach the memory, so they keep their last
                // values across rejected requests and idle periods.
                if (sel_err) begin
                    rsp_rdata <= 32'd0;
                end else begin
                    mem_addr  <= sel_addr;
                    mem_wdata <= sel_wdata;
                    mem_ctrl  <= sel_we ? {1'b0, sel_ctrl[1:0]} : sel_ctrl;
                end
            end
            if (state == ACCESS) begin
                rsp_rdata <= we_q ? 32'd0 : mem_rdata;
            end
        end
    end

    // gnt is gated with rst_n so a request held through reset is not accepted.
    assign p0_gnt  = rst_n & grant & ~pick_p1;
    assign p1_gnt  = rst_n & grant &  pick_p1;
    assign p0_done = (state == RESP) & ~owner;
    assign p1_done = (state == RESP) &  owner;
    assign rsp_err = (state == RESP) & err_q;
    assign busy    = (state != IDLE);
    assign mem_wr  = (state == ACCESS) & we_q;

endmodule
